// File: rtl/restoring_divider.sv
// Sequential 8-bit unsigned restoring divider: one shift/subtract/restore step per enabled clock.
// Quotient and remainder are read straight from the working registers once done is high.
module restoring_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enable,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       done
);

  logic [8:0] r_a;
  logic [7:0] r_q;
  logic [7:0] r_m;
  logic [3:0] r_cnt;
  logic       r_done;

  logic [8:0] w_shift_a;
  logic [7:0] w_shift_q;
  logic [8:0] w_trial;
  logic       w_step;

  // The partial remainder stays below M, so the shifted value is below 2*M and
  // bit 8 of the 9-bit difference is a reliable "went negative" flag.
  assign w_shift_a = {r_a[7:0], r_q[7]};
  assign w_shift_q = {r_q[6:0], 1'b0};
  assign w_trial   = w_shift_a - {1'b0, r_m};
  assign w_step    = enable && !r_done && (r_cnt < 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (start) begin
      r_a    <= '0;
      r_q    <= dividend;
      r_m    <= divisor;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_step) begin
      if (w_trial[8]) begin
        r_a <= w_shift_a;
        r_q <= w_shift_q;
      end else begin
        r_a <= w_trial;
        r_q <= w_shift_q | 8'd1;
      end
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd7) begin
        r_done <= 1'b1;
      end
    end
  end

  assign quotient  = r_q;
  assign remainder = r_a[7:0];
  assign done      = r_done;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: stimulus pushes expected {quotient, remainder},
// a monitor pops and compares on every rising edge of done.
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic        done_prev = 1'b0;

  restoring_divider dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .enable   (enable),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Monitor: result is presented when done rises.
  always @(negedge clk) begin
    logic [15:0] e;
    if (done && !done_prev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got q=%0d r=%0d, required no result pending", quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        if (quotient !== e[15:8] || remainder !== e[7:0]) begin
          n_err++;
          $display("FAIL result: got q=%0d r=%0d, required q=%0d r=%0d",
                   quotient, remainder, e[15:8], e[7:0]);
        end else begin
          $display("result ok: q=%0d r=%0d", quotient, remainder);
        end
      end
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    enable = 1'b0;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    // Operand changes after the load must not matter.
    dividend = 8'($urandom);
    divisor = 8'($urandom);
    chk("done_low_after_start", {7'd0, done}, 8'd0);
  endtask

  task automatic run(input int n);
    enable = 1'b1;
    repeat (n) tick();
    enable = 1'b0;
  endtask

  task automatic divide(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er);
    exp_q.push_back({eq, er});
    $display("divide %0d / %0d, expecting q=%0d r=%0d", a, b, eq, er);
    do_start(a, b);
    run(8);
    chk("done_after_8", {7'd0, done}, 8'd1);
    tick();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_quotient", quotient, 8'd0);
    chk("rst_remainder", remainder, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    rst = 1'b0;
    tick();

    // Basic divisions
    divide(8'd100, 8'd3, 8'd33, 8'd1);
    divide(8'd7, 8'd8, 8'd0, 8'd7);
    divide(8'd255, 8'd5, 8'd51, 8'd0);
    divide(8'd50, 8'd25, 8'd2, 8'd0);

    // Pause in the middle
    exp_q.push_back({8'd28, 8'd4});
    $display("divide 200 / 7 with pause, expecting q=28 r=4");
    do_start(8'd200, 8'd7);
    run(4);
    repeat (3) begin
      tick();
      chk("done_low_in_pause", {7'd0, done}, 8'd0);
    end
    run(3);
    chk("done_low_after_7", {7'd0, done}, 8'd0);
    run(1);
    chk("done_after_pause", {7'd0, done}, 8'd1);
    tick();

    // Divide by zero
    divide(8'd77, 8'd0, 8'd255, 8'd77);

    // Hold after done
    divide(8'd100, 8'd3, 8'd33, 8'd1);
    enable = 1'b1;
    repeat (5) begin
      tick();
      chk("hold_quotient", quotient, 8'd33);
      chk("hold_remainder", remainder, 8'd1);
      chk("hold_done", {7'd0, done}, 8'd1);
    end
    enable = 1'b0;

    // Abort by reset
    $display("divide 100 / 3 aborted by reset");
    do_start(8'd100, 8'd3);
    run(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rst_quotient", quotient, 8'd0);
    chk("abort_rst_remainder", remainder, 8'd0);
    chk("abort_rst_done", {7'd0, done}, 8'd0);
    tick();

    // Abort by restart
    $display("divide 100 / 3 restarted with 9 / 2, expecting q=4 r=1");
    do_start(8'd100, 8'd3);
    run(3);
    exp_q.push_back({8'd4, 8'd1});
    do_start(8'd9, 8'd2);
    run(8);
    chk("done_after_restart", {7'd0, done}, 8'd1);
    tick();
    tick();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL results_outstanding: got %0d pending, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
